// File: rtl/phys_free_list.sv
// phys_free_list
//   Physical-register free list for the rename stage. It is a circular FIFO
//   of physical register numbers. Rename allocates up to four per cycle from
//   the head, and retirement returns up to four per cycle at the tail.
//   Ports:
//     i_clk, i_rst_n            clock, async active-low reset
//     i_alloc_count             registers requested by rename (0..4)
//     o_alloc_p0..o_alloc_p3    next four entries at head, oldest first
//     o_alloc_ok                request can be granted this cycle
//     i_free_count              registers returned by the ROB (0..4)
//     i_free_p0..i_free_p3      returned register numbers
//     o_free_count              current occupancy (0..64)
//     o_err                     sticky protocol-error flag
module phys_free_list #(
  parameter int NUM_PREGS = 64,
  parameter int NUM_AREGS = 32
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [2:0] i_alloc_count,
  output logic [5:0] o_alloc_p0,
  output logic [5:0] o_alloc_p1,
  output logic [5:0] o_alloc_p2,
  output logic [5:0] o_alloc_p3,
  output logic       o_alloc_ok,
  input  logic [2:0] i_free_count,
  input  logic [5:0] i_free_p0,
  input  logic [5:0] i_free_p1,
  input  logic [5:0] i_free_p2,
  input  logic [5:0] i_free_p3,
  output logic [6:0] o_free_count,
  output logic       o_err
);

  // Registers beyond the architectural set start out free.
  localparam int NUM_INIT = NUM_PREGS - NUM_AREGS;

  logic [5:0] mem [NUM_PREGS];
  logic [5:0] head;
  logic [5:0] tail;
  logic [6:0] count;
  logic       err;

  logic [5:0] rd_idx [4];
  logic [5:0] wr_idx [4];
  logic [5:0] free_p [4];

  logic       alloc_legal;
  logic       alloc_ok;
  logic [2:0] alloc_amt;
  logic [7:0] occ_after;
  logic       free_legal;
  logic [2:0] free_amt;

  // 6-bit index arithmetic wraps modulo 64 on its own.
  always_comb begin
    free_p[0] = i_free_p0;
    free_p[1] = i_free_p1;
    free_p[2] = i_free_p2;
    free_p[3] = i_free_p3;
    for (int k = 0; k < 4; k++) begin
      rd_idx[k] = head + 6'(k);
      wr_idx[k] = tail + 6'(k);
    end
  end

  assign o_alloc_p0 = mem[rd_idx[0]];
  assign o_alloc_p1 = mem[rd_idx[1]];
  assign o_alloc_p2 = mem[rd_idx[2]];
  assign o_alloc_p3 = mem[rd_idx[3]];

  // The allocate check sees only the registered count. A same-cycle free
  // cannot satisfy an allocation.
  assign alloc_legal = (i_alloc_count <= 3'd4);
  assign alloc_ok    = alloc_legal && (count >= {4'b0, i_alloc_count});
  assign alloc_amt   = alloc_ok ? i_alloc_count : 3'd0;

  // The overflow check includes the allocation granted in this cycle. A full
  // list can therefore take a free of N while it hands out N.
  assign occ_after  = {1'b0, count} - {5'b0, alloc_amt} + {5'b0, i_free_count};
  assign free_legal = (i_free_count <= 3'd4) && (occ_after <= 8'(NUM_PREGS));
  assign free_amt   = free_legal ? i_free_count : 3'd0;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < NUM_PREGS; i++) begin
        mem[i] <= (i < NUM_INIT) ? 6'(NUM_AREGS + i) : 6'd0;
      end
      head  <= 6'd0;
      tail  <= 6'(NUM_INIT);
      count <= 7'(NUM_INIT);
      err   <= 1'b0;
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (3'(k) < free_amt) mem[wr_idx[k]] <= free_p[k];
      end
      head  <= head + {3'b0, alloc_amt};
      tail  <= tail + {3'b0, free_amt};
      count <= count - {4'b0, alloc_amt} + {4'b0, free_amt};
      // Back-pressure (count too small) is not an error; bad counts and
      // overflowing frees are.
      if (!alloc_legal || !free_legal) err <= 1'b1;
    end
  end

  assign o_alloc_ok   = alloc_ok;
  assign o_free_count = count;
  assign o_err        = err;

endmodule

// File: tb/tb_phys_free_list.sv
module tb_phys_free_list;

  logic       clk;
  logic       rst_n;
  logic [2:0] ac;
  logic [2:0] fn;
  logic [5:0] f0, f1, f2, f3;
  logic [5:0] p0, p1, p2, p3;
  logic       ok;
  logic [6:0] fc;
  logic       err;

  phys_free_list dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_alloc_count(ac),
    .o_alloc_p0   (p0),
    .o_alloc_p1   (p1),
    .o_alloc_p2   (p2),
    .o_alloc_p3   (p3),
    .o_alloc_ok   (ok),
    .i_free_count (fn),
    .i_free_p0    (f0),
    .i_free_p1    (f1),
    .i_free_p2    (f2),
    .i_free_p3    (f3),
    .o_free_count (fc),
    .o_err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      tag;
    logic [3:0] pmask;
    logic [5:0] e0, e1, e2, e3;
    logic       eok;
    logic [6:0] efc;
    logic       eerr;
  } exp_t;

  exp_t q[$];
  exp_t m;
  int   total  = 0;
  int   passed = 0;

  task automatic chk(input string name, input int act, input int want);
    total++;
    if (act == want) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, want);
  endtask

  // Monitor: outputs are sampled mid-cycle, after inputs settle.
  always @(negedge clk) begin
    if (q.size() != 0) begin
      m = q.pop_front();
      if (m.pmask[3]) chk({m.tag, ".p0"}, int'(p0), int'(m.e0));
      if (m.pmask[2]) chk({m.tag, ".p1"}, int'(p1), int'(m.e1));
      if (m.pmask[1]) chk({m.tag, ".p2"}, int'(p2), int'(m.e2));
      if (m.pmask[0]) chk({m.tag, ".p3"}, int'(p3), int'(m.e3));
      chk({m.tag, ".ok"},  int'(ok),  int'(m.eok));
      chk({m.tag, ".cnt"}, int'(fc),  int'(m.efc));
      chk({m.tag, ".err"}, int'(err), int'(m.eerr));
    end
  end

  task automatic push(input string tag, input logic [3:0] pm,
                      input int e0, input int e1, input int e2, input int e3,
                      input logic eok, input int efc, input logic eerr);
    exp_t e;
    e.tag = tag; e.pmask = pm;
    e.e0 = 6'(e0); e.e1 = 6'(e1); e.e2 = 6'(e2); e.e3 = 6'(e3);
    e.eok = eok; e.efc = 7'(efc); e.eerr = eerr;
    q.push_back(e);
  endtask

  task automatic cyc(input int a, input int n,
                     input int v0, input int v1, input int v2, input int v3,
                     input string tag, input logic [3:0] pm,
                     input int e0, input int e1, input int e2, input int e3,
                     input logic eok, input int efc, input logic eerr);
    @(posedge clk);
    #1;
    ac = 3'(a); fn = 3'(n);
    f0 = 6'(v0); f1 = 6'(v1); f2 = 6'(v2); f3 = 6'(v3);
    push(tag, pm, e0, e1, e2, e3, eok, efc, eerr);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0; ac = 3'd0; fn = 3'd0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; ac = 3'd0; fn = 3'd0;
    f0 = 6'd0; f1 = 6'd0; f2 = 6'd0; f3 = 6'd0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset contents, then drain to empty.
    cyc(4, 0, 0, 0, 0, 0, "rst_alloc", 4'hF, 32, 33, 34, 35, 1, 32, 0);
    cyc(4, 0, 0, 0, 0, 0, "alloc2",    4'hF, 36, 37, 38, 39, 1, 28, 0);
    for (int n = 0; n < 6; n++)
      cyc(4, 0, 0, 0, 0, 0, "drain", 4'hF,
          40 + 4*n, 41 + 4*n, 42 + 4*n, 43 + 4*n, 1, 24 - 4*n, 0);
    cyc(1, 0, 0, 0, 0, 0, "empty_rej",  4'h0, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 4, 5, 9, 12, 7, "free_empty", 4'h0, 0, 0, 0, 0, 1, 0, 0);
    cyc(4, 0, 0, 0, 0, 0, "realloc",    4'hF, 5, 9, 12, 7, 1, 4, 0);
    cyc(0, 0, 0, 0, 0, 0, "idle",       4'h0, 0, 0, 0, 0, 1, 0, 0);

    // Mixed alloc 3 / free 2; the freed values come after the 29 originals.
    do_reset();
    cyc(3, 2, 1, 2, 0, 0, "mix", 4'hF, 32, 33, 34, 35, 1, 32, 0);
    for (int i = 0; i < 7; i++)
      cyc(4, 0, 0, 0, 0, 0, "order", 4'hF,
          35 + 4*i, 36 + 4*i, 37 + 4*i, 38 + 4*i, 1, 31 - 4*i, 0);
    cyc(3, 0, 0, 0, 0, 0, "tail_vals", 4'b1110, 63, 1, 2, 0, 1, 3, 0);

    // Walk head and tail from 34 up to 62 with the list empty, then wrap.
    cyc(0, 4, 10, 11, 12, 13, "w_fill", 4'h0, 0, 0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 6; i++)
      cyc(4, 4, 14 + 4*i, 15 + 4*i, 16 + 4*i, 17 + 4*i, "walk", 4'hF,
          10 + 4*i, 11 + 4*i, 12 + 4*i, 13 + 4*i, 1, 4, 0);
    cyc(4, 0, 0, 0, 0, 0, "walk_end", 4'hF, 34, 35, 36, 37, 1, 4, 0);
    cyc(0, 4, 40, 41, 42, 43, "wrap_free", 4'h0, 0, 0, 0, 0, 1, 0, 0);
    cyc(4, 4, 44, 45, 46, 47, "wrap_both", 4'hF, 40, 41, 42, 43, 1, 4, 0);
    cyc(0, 0, 0, 0, 0, 0, "wrap_after", 4'hF, 44, 45, 46, 47, 1, 4, 0);

    // Fill to 64, overflow, illegal alloc, legal swap at full, sticky err.
    do_reset();
    for (int i = 0; i < 8; i++)
      cyc(0, 4, 4*i, 4*i + 1, 4*i + 2, 4*i + 3, "fill", 4'h0,
          0, 0, 0, 0, 1, 32 + 4*i, 0);
    cyc(0, 4, 1, 1, 1, 1, "full_free", 4'h0, 0, 0, 0, 0, 1, 64, 0);
    cyc(5, 0, 0, 0, 0, 0, "bad_alloc", 4'h0, 0, 0, 0, 0, 0, 64, 1);
    cyc(4, 4, 50, 51, 52, 53, "full_swap", 4'hF, 32, 33, 34, 35, 1, 64, 1);
    cyc(0, 0, 0, 0, 0, 0, "sticky", 4'hF, 36, 37, 38, 39, 1, 64, 1);

    // Asynchronous reset in the middle of a cycle.
    @(posedge clk);
    #1 ac = 3'd0; fn = 3'd0;
    #2 rst_n = 1'b0;
    push("mid_rst", 4'hF, 32, 33, 34, 35, 1, 32, 0);
    @(negedge clk);
    #1 rst_n = 1'b1;
    cyc(0, 0, 0, 0, 0, 0, "post_rst", 4'hF, 32, 33, 34, 35, 1, 32, 0);

    // A free count above four is dropped and flagged.
    cyc(0, 5, 9, 9, 9, 9, "bad_free", 4'hF, 32, 33, 34, 35, 1, 32, 0);
    cyc(0, 0, 0, 0, 0, 0, "bad_free_eff", 4'hF, 32, 33, 34, 35, 1, 32, 1);

    repeat (3) @(negedge clk);
    #1;
    chk("queue_drained", q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/phys_free_list.md
# phys_free_list

Physical-register free list for the out-of-order core's rename stage. It consumes the `old_p` physical registers that the 16-entry reorder buffer releases at retirement, up to four per cycle. It supplies up to four fresh physical registers per cycle to rename/dispatch, and those feed the destination fields of the ROB instruction bundles. Storage is a 64-entry circular FIFO of 6-bit register numbers, with an occupancy count and sticky protocol-error detection.

## Interface
- `NUM_PREGS`, 64: physical registers; the pointer width is log2 of this (6).
- `NUM_AREGS`, 32: architectural registers; p0..p31 are mapped at reset and are not on the list.
- `i_clk`  in  1  clock; all state updates on the rising edge.
- `i_rst_n`  in  1  reset; asynchronous, active-low.
- `i_alloc_count`  in  3  number of registers rename takes this cycle, 0..4.
- `o_alloc_p0`..`o_alloc_p3`  out  6 each  the next four list entries, oldest first.
- `o_alloc_ok`  out  1  high when `o_free_count >= i_alloc_count` and `i_alloc_count <= 4`.
- `i_free_count`  in  3  number of registers the ROB retires this cycle, 0..4.
- `i_free_p0`..`i_free_p3`  in  6 each  retired `old_p` values; only the first `i_free_count` are used.
- `o_free_count`  out  7  current occupancy, 0..64.
- `o_err`  out  1  sticky protocol-error flag.

## Operation
- State:
  - `mem[0:63]` holds 6-bit entries.
  - `head` and `tail` are 6-bit pointers that wrap modulo 64 naturally.
  - `count` is 7 bits.
  - `err` is 1 bit.
- Reset (asynchronous, any time, including mid-operation):
  - `mem[i] = 32+i` for i in 0..31; `mem[32..63] = 0`.
  - `head = 0`, `tail = 32`, `count = 32`, `err = 0`.
  - Resulting outputs: `o_alloc_p0..3 = 32,33,34,35`, `o_free_count = 32`, `o_err = 0`.
- Allocate port:
  - `o_alloc_pk = mem[head+k]`, combinational from registered state.
  - Entries with k >= `count` are don't-care.
  - The request is accepted iff `o_alloc_ok`; then `head += i_alloc_count`.
  - Allocation is all-or-nothing: a rejected request changes nothing.
  - `i_alloc_count = 0` is always ok and has no effect.
- Free port:
  - Writes `mem[tail+k] = i_free_pk` for k < `i_free_count`, then `tail += i_free_count`.
  - The free is legal iff `i_free_count <= 4` and `count - accepted_alloc + i_free_count <= 64`.
  - An illegal free is dropped entirely: no write, no `tail` move, and `err` is set.
- Illegal allocate: `i_alloc_count` of 5..7 sets `err`, `o_alloc_ok = 0`, no state change.
- A rejected request because `count` is too small is back-pressure, not an error; `err` is unaffected.
- Count update: `count_next = count - (accepted ? i_alloc_count : 0) + (free_legal ? i_free_count : 0)`.
- Simultaneous events:
  - Allocate and free are independent in the same cycle.
  - The allocation check uses registered `count` only; same-cycle frees are not bypassed.
  - Head and tail may cross `mem` index 63→0 within one multi-entry operation.
- `err` clears only on reset.
- The block does not check for duplicate registers or for freeing p0.

## Timing
- Allocate data and `o_alloc_ok` are combinational from state; they are valid in the same cycle the request is presented.
- A register freed in cycle N is visible on `o_alloc_p*` from cycle N+1, once it reaches the head position. Free-to-allocate latency is 1 cycle.
- `o_free_count` and `o_err` are registered; they reflect updates from the previous edge.
- Full (`count = 64`): any `i_free_count > 0` without a matching allocation is an error.
- Empty (`count = 0`): `o_alloc_ok = 0` for any nonzero request.
- Throughput: up to 4 allocations and 4 frees per cycle, sustained, with no bubbles.

## Test plan
- Reset, then allocate 4 → that cycle `o_alloc_p0..3 = 32..35`. Next cycle: `o_alloc_p0..3 = 36..39`, `o_free_count = 28`.
- Allocate 4 per cycle for 8 cycles → `o_free_count = 0`. Then allocate 1 → `o_alloc_ok = 0`, count stays 0, `o_err = 0`.
- While empty, free 4 (p5, p9, p12, p7) → next cycle `o_free_count = 4`, `o_alloc_p0..3 = 5,9,12,7`.
- Same cycle, allocate 3 and free 2 from the reset state → `o_free_count = 31`. Freed values appear after the remaining 29 originals.
- Wrap: cycle the list until `head = 62` and `tail = 62`. Then free 4 and allocate 4 → entries cross index 63→0 in order and `count` is unchanged.
- From the reset state: free 4 with `count = 64` → free dropped, `o_err = 1`. Then `i_alloc_count = 5` → `o_alloc_ok = 0`, `o_err` stays 1. Then pulse `i_rst_n` low mid-cycle → outputs return immediately to 32..35, count 32, `o_err = 0`.
